// File: rtl/alu_cmd_ctrl.sv
// alu_cmd_ctrl
//   Byte-command front end for an ALU driven by a UART receiver and transmitter.
//   Command bytes select operand A, operand B or opcode writes. The data byte
//   that follows a write command is captured into the selected register. Other
//   commands request transmission of the ALU result or of a status byte.
//   Errors transmit ERR_CODE: an unknown command byte, a timeout while waiting
//   for an operand byte, or a result request before A, B and opcode are all valid.
//
// Ports
//   clk, rst      : clock and synchronous active-high reset
//   i_rx_data     : received byte, qualified by the single-cycle i_rx_valid
//   i_result      : combinational ALU result from o_A/o_B/o_op
//   i_tx_done     : transmitter end-of-frame pulse
//   o_A/o_B/o_op  : registered operands and opcode
//   o_tx_data     : byte to transmit, held until the next transmit
//   o_tx_start    : single-cycle transmit request
//   o_busy        : high while a transmit is outstanding
//   o_drop        : pulses when a received byte is discarded during a transmit
module alu_cmd_ctrl #(
  parameter int         N        = 8,
  parameter logic [7:0] CMD_A    = 8'h01,
  parameter logic [7:0] CMD_B    = 8'h02,
  parameter logic [7:0] CMD_OP   = 8'h03,
  parameter logic [7:0] CMD_R    = 8'h04,
  parameter logic [7:0] CMD_ST   = 8'h05,
  parameter logic [7:0] ERR_CODE = 8'hEE,
  parameter int         TIMEOUT  = 1000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] i_rx_data,
  input  logic         i_rx_valid,
  input  logic [N-1:0] i_result,
  input  logic         i_tx_done,
  output logic [N-1:0] o_A,
  output logic [N-1:0] o_B,
  output logic [N-1:0] o_op,
  output logic [N-1:0] o_tx_data,
  output logic         o_tx_start,
  output logic         o_busy,
  output logic         o_drop
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [N-1:0] CMD_A_N  = N'(CMD_A);
  localparam logic [N-1:0] CMD_B_N  = N'(CMD_B);
  localparam logic [N-1:0] CMD_OP_N = N'(CMD_OP);
  localparam logic [N-1:0] CMD_R_N  = N'(CMD_R);
  localparam logic [N-1:0] CMD_ST_N = N'(CMD_ST);
  localparam logic [N-1:0] ERR_N    = N'(ERR_CODE);

  typedef enum logic [2:0] {IDLE, WAIT_A, WAIT_B, WAIT_OP, SEND, WAIT_DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             va, vb, vop, unk_flag, to_flag;

  logic             tx_load, set_unk, set_to, clr_err, cnt_clr, cnt_inc;
  logic             wr_a, wr_b, wr_op;
  logic [N-1:0]     tx_nxt;

  function automatic logic [N-1:0] status_byte(input logic t, input logic u,
                                                input logic o, input logic b,
                                                input logic a);
    return {{(N-5){1'b0}}, t, u, o, b, a};
  endfunction

  always_comb begin
    state_nxt = state;
    tx_load   = 1'b0;
    tx_nxt    = o_tx_data;
    set_unk   = 1'b0;
    set_to    = 1'b0;
    clr_err   = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    wr_a      = 1'b0;
    wr_b      = 1'b0;
    wr_op     = 1'b0;
    case (state)
      IDLE: begin
        if (i_rx_valid) begin
          cnt_clr = 1'b1;
          if (i_rx_data == CMD_A_N)       state_nxt = WAIT_A;
          else if (i_rx_data == CMD_B_N)  state_nxt = WAIT_B;
          else if (i_rx_data == CMD_OP_N) state_nxt = WAIT_OP;
          else begin
            state_nxt = SEND;
            tx_load   = 1'b1;
            if (i_rx_data == CMD_R_N) begin
              tx_nxt = (va && vb && vop) ? i_result : ERR_N;
            end else if (i_rx_data == CMD_ST_N) begin
              tx_nxt  = status_byte(to_flag, unk_flag, vop, vb, va);
              clr_err = 1'b1;
            end else begin
              tx_nxt  = ERR_N;
              set_unk = 1'b1;
            end
          end
        end
      end
      WAIT_A, WAIT_B, WAIT_OP: begin
        if (i_rx_valid) begin
          wr_a      = (state == WAIT_A);
          wr_b      = (state == WAIT_B);
          wr_op     = (state == WAIT_OP);
          state_nxt = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_nxt = SEND;
          tx_load   = 1'b1;
          tx_nxt    = ERR_N;
          set_to    = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      SEND:      state_nxt = WAIT_DONE;
      WAIT_DONE: if (i_tx_done) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      va        <= 1'b0;
      vb        <= 1'b0;
      vop       <= 1'b0;
      unk_flag  <= 1'b0;
      to_flag   <= 1'b0;
      o_A       <= '0;
      o_B       <= '0;
      o_op      <= '0;
      o_tx_data <= '0;
    end else begin
      state <= state_nxt;
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + 1'b1;
      if (wr_a)  begin o_A  <= i_rx_data; va  <= 1'b1; end
      if (wr_b)  begin o_B  <= i_rx_data; vb  <= 1'b1; end
      if (wr_op) begin o_op <= i_rx_data; vop <= 1'b1; end
      // Error flags are sticky until a status byte has been captured for transmit.
      if (clr_err) begin
        unk_flag <= 1'b0;
        to_flag  <= 1'b0;
      end else begin
        if (set_unk) unk_flag <= 1'b1;
        if (set_to)  to_flag  <= 1'b1;
      end
      if (tx_load) o_tx_data <= tx_nxt;
    end
  end

  assign o_tx_start = (state == SEND);
  assign o_busy     = (state == SEND) || (state == WAIT_DONE);
  assign o_drop     = i_rx_valid && o_busy;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
module tb_alu_cmd_ctrl;

  localparam int N  = 8;
  localparam int TO = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] i_rx_data;
  logic         i_rx_valid;
  logic [N-1:0] i_result;
  logic         i_tx_done;
  logic [N-1:0] o_A, o_B, o_op, o_tx_data;
  logic         o_tx_start, o_busy, o_drop;

  int pass_cnt  = 0;
  int total_cnt = 0;

  alu_cmd_ctrl #(.N(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
    .i_result(i_result), .i_tx_done(i_tx_done), .o_A(o_A), .o_B(o_B),
    .o_op(o_op), .o_tx_data(o_tx_data), .o_tx_start(o_tx_start),
    .o_busy(o_busy), .o_drop(o_drop)
  );

  always #5 clk = ~clk;

  // Drives one received byte for one cycle; returns at the falling edge after
  // the byte was sampled, so a transmit request is visible on return.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    @(negedge clk);
    i_rx_valid = 1'b0;
  endtask

  task automatic tx_done_pulse();
    @(negedge clk);
    i_tx_done = 1'b1;
    @(negedge clk);
    i_tx_done = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++;
    if ({o_A, o_B, o_op, o_tx_data} !== 32'h0)
      $display("FAIL reset_regs: got %h expected 00000000", {o_A, o_B, o_op, o_tx_data});
    else pass_cnt++;
    total_cnt++;
    if ({o_tx_start, o_busy, o_drop} !== 3'b000)
      $display("FAIL reset_ctrl: got %b expected 000", {o_tx_start, o_busy, o_drop});
    else pass_cnt++;
  endtask

  task automatic test_write_result();
    do_reset();
    send_byte(8'h01); send_byte(8'h05);
    send_byte(8'h02); send_byte(8'h03);
    send_byte(8'h03); send_byte(8'h07);
    total_cnt++;
    if ({o_A, o_B, o_op} !== 24'h050307)
      $display("FAIL write_regs: got %h expected 050307", {o_A, o_B, o_op});
    else pass_cnt++;
    i_result = 8'h08;
    send_byte(8'h04);
    total_cnt++;
    if ({o_tx_start, o_busy, o_tx_data} !== {2'b11, 8'h08})
      $display("FAIL result_tx: got start=%b busy=%b data=%h expected 1 1 08",
               o_tx_start, o_busy, o_tx_data);
    else pass_cnt++;
    i_result = 8'h55;
    @(negedge clk);
    total_cnt++;
    if ({o_tx_start, o_busy, o_tx_data} !== {2'b01, 8'h08})
      $display("FAIL result_hold: got start=%b busy=%b data=%h expected 0 1 08",
               o_tx_start, o_busy, o_tx_data);
    else pass_cnt++;
    tx_done_pulse();
    total_cnt++;
    if (o_busy !== 1'b0) $display("FAIL done_idle: got busy=%b expected 0", o_busy);
    else pass_cnt++;
  endtask

  task automatic test_not_valid();
    do_reset();
    i_result = 8'h42;
    send_byte(8'h04);
    total_cnt++;
    if (o_tx_data !== 8'hEE) $display("FAIL result_invalid: got %h expected ee", o_tx_data);
    else pass_cnt++;
    tx_done_pulse();
    send_byte(8'h05);
    total_cnt++;
    if (o_tx_data !== 8'h00) $display("FAIL status_clean: got %h expected 00", o_tx_data);
    else pass_cnt++;
    tx_done_pulse();
  endtask

  task automatic test_unknown();
    do_reset();
    send_byte(8'h09);
    total_cnt++;
    if ({o_tx_start, o_tx_data} !== {1'b1, 8'hEE})
      $display("FAIL unknown_err: got start=%b data=%h expected 1 ee", o_tx_start, o_tx_data);
    else pass_cnt++;
    tx_done_pulse();
    send_byte(8'h05);
    total_cnt++;
    if (o_tx_data !== 8'h08) $display("FAIL unknown_status: got %h expected 08", o_tx_data);
    else pass_cnt++;
    tx_done_pulse();
    send_byte(8'h05);
    total_cnt++;
    if (o_tx_data !== 8'h00) $display("FAIL unknown_cleared: got %h expected 00", o_tx_data);
    else pass_cnt++;
    tx_done_pulse();
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    send_byte(8'h01); send_byte(8'h5A);
    // A byte after TO-1 idle cycles is still accepted.
    send_byte(8'h01);
    repeat (TO - 2) @(negedge clk);
    send_byte(8'h3C);
    total_cnt++;
    if ({o_busy, o_A} !== {1'b0, 8'h3C})
      $display("FAIL timeout_edge: got busy=%b A=%h expected 0 3c", o_busy, o_A);
    else pass_cnt++;
    send_byte(8'h01);
    n = 0;
    while (!o_tx_start && n < TO + 10) begin
      @(negedge clk);
      n++;
    end
    total_cnt++;
    if (n !== TO) $display("FAIL timeout_cycles: got %0d expected %0d", n, TO);
    else pass_cnt++;
    total_cnt++;
    if ({o_tx_data, o_A} !== 16'hEE3C)
      $display("FAIL timeout_err: got data=%h A=%h expected ee 3c", o_tx_data, o_A);
    else pass_cnt++;
    tx_done_pulse();
    send_byte(8'h05);
    total_cnt++;
    if (o_tx_data !== 8'h11) $display("FAIL timeout_status: got %h expected 11", o_tx_data);
    else pass_cnt++;
    tx_done_pulse();
  endtask

  task automatic test_drop();
    int drops;
    do_reset();
    send_byte(8'h01); send_byte(8'h11);
    send_byte(8'h02); send_byte(8'h22);
    send_byte(8'h03); send_byte(8'h33);
    i_result = 8'h99;
    send_byte(8'h04);
    drops = 0;
    i_rx_valid = 1'b1;
    i_rx_data  = 8'h01;
    #1 if (o_drop) drops++;
    @(negedge clk); i_rx_data = 8'h02;
    #1 if (o_drop) drops++;
    @(negedge clk); i_rx_data = 8'h09;
    #1 if (o_drop) drops++;
    @(negedge clk); i_rx_valid = 1'b0;
    total_cnt++;
    if (drops !== 3) $display("FAIL drop_count: got %0d expected 3", drops);
    else pass_cnt++;
    total_cnt++;
    if ({o_busy, o_A, o_B, o_op, o_tx_data} !== {1'b1, 32'h11223399})
      $display("FAIL drop_regs: got busy=%b %h %h %h %h expected 1 11 22 33 99",
               o_busy, o_A, o_B, o_op, o_tx_data);
    else pass_cnt++;
    // Byte coincident with tx_done is dropped, FSM still returns to IDLE.
    i_rx_valid = 1'b1; i_rx_data = 8'h01; i_tx_done = 1'b1;
    #1;
    total_cnt++;
    if (o_drop !== 1'b1) $display("FAIL drop_on_done: got %b expected 1", o_drop);
    else pass_cnt++;
    @(negedge clk);
    i_rx_valid = 1'b0; i_tx_done = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({o_busy, o_tx_start, o_A} !== {2'b00, 8'h11})
      $display("FAIL drop_done_idle: got busy=%b start=%b A=%h expected 0 0 11",
               o_busy, o_tx_start, o_A);
    else pass_cnt++;
    // Stray tx_done in IDLE is ignored.
    tx_done_pulse();
    send_byte(8'h05);
    total_cnt++;
    if ({o_tx_start, o_tx_data} !== {1'b1, 8'h07})
      $display("FAIL drop_status: got start=%b data=%h expected 1 07", o_tx_start, o_tx_data);
    else pass_cnt++;
    tx_done_pulse();
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_byte(8'h01); send_byte(8'h44);
    send_byte(8'h04);
    @(negedge clk);
    total_cnt++;
    if ({o_tx_start, o_busy} !== 2'b01)
      $display("FAIL mid_wait_done: got start=%b busy=%b expected 0 1", o_tx_start, o_busy);
    else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total_cnt++;
    if ({o_A, o_B, o_op, o_tx_data, o_tx_start, o_busy, o_drop} !== 35'h0)
      $display("FAIL mid_reset: got %h expected 0",
               {o_A, o_B, o_op, o_tx_data, o_tx_start, o_busy, o_drop});
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({o_tx_start, o_busy} !== 2'b00)
      $display("FAIL mid_after: got start=%b busy=%b expected 0 0", o_tx_start, o_busy);
    else pass_cnt++;
    send_byte(8'h01); send_byte(8'hAA);
    total_cnt++;
    if (o_A !== 8'hAA) $display("FAIL mid_rewrite: got %h expected aa", o_A);
    else pass_cnt++;
    send_byte(8'h05);
    total_cnt++;
    if (o_tx_data !== 8'h01) $display("FAIL mid_status: got %h expected 01", o_tx_data);
    else pass_cnt++;
    tx_done_pulse();
  endtask

  initial begin
    rst        = 1'b1;
    i_rx_data  = '0;
    i_rx_valid = 1'b0;
    i_result   = '0;
    i_tx_done  = 1'b0;
    test_reset();
    test_write_result();
    test_not_valid();
    test_unknown();
    test_timeout();
    test_drop();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/alu_cmd_ctrl.md
ALU_CMD_CTRL -- requirements
Module: alu_cmd_ctrl

Interface
REQ-001 Parameter N, default 8, data/operand width in bits; N SHALL be >= 8.
REQ-002 Parameter CMD_A, default 8'h01, command byte selecting operand A write.
REQ-003 Parameter CMD_B, default 8'h02, command byte selecting operand B write.
REQ-004 Parameter CMD_OP, default 8'h03, command byte selecting opcode write.
REQ-005 Parameter CMD_R, default 8'h04, command byte requesting result transmit.
REQ-006 Parameter CMD_ST, default 8'h05, command byte requesting status transmit.
REQ-007 Parameter ERR_CODE, default 8'hEE, byte transmitted on any error.
REQ-008 Parameter TIMEOUT, default 1000, maximum idle cycles allowed while waiting for an operand byte.
REQ-009 clk  in  1  clock; all state updates on the rising edge.
REQ-010 rst  in  1  reset, synchronous, active-high.
REQ-011 i_rx_data  in  N  received byte from the UART receiver.
REQ-012 i_rx_valid  in  1  single-cycle pulse qualifying i_rx_data.
REQ-013 i_result  in  N  ALU result, combinational from o_A/o_B/o_op.
REQ-014 i_tx_done  in  1  single-cycle pulse from the transmitter at end of frame.
REQ-015 o_A, o_B, o_op  out  N each  registered operand and opcode to the ALU.
REQ-016 o_tx_data  out  N  byte to transmit.
REQ-017 o_tx_start  out  1  single-cycle transmit request.
REQ-018 o_busy  out  1  high in SEND and WAIT_DONE states.
REQ-019 o_drop  out  1  single-cycle pulse when an i_rx_valid byte is discarded.

Function
REQ-020 FSM states SHALL be IDLE, WAIT_A, WAIT_B, WAIT_OP, SEND, WAIT_DONE.
REQ-021 IDLE + i_rx_valid: CMD_A/CMD_B/CMD_OP -> matching WAIT state; CMD_R/CMD_ST -> SEND; any other byte -> SEND with ERR_CODE.
REQ-022 WAIT_x + i_rx_valid at cycle t: target register SHALL show i_rx_data at t+1, its valid flag (va/vb/vop) SHALL set, FSM -> IDLE.
REQ-023 WAIT_x: a timeout counter SHALL clear on entry and increment each cycle without i_rx_valid; reaching TIMEOUT -> SEND with ERR_CODE, register and flag unchanged.
REQ-024 CMD_R at cycle t: if va&vb&vop, o_tx_data SHALL equal i_result sampled at t; otherwise ERR_CODE.
REQ-025 CMD_ST: o_tx_data SHALL be zero-extended {timeout_flag, unknown_flag, vop, vb, va}, bit 0 = va.
REQ-026 unknown_flag and timeout_flag SHALL be sticky, set on the corresponding error, and cleared only by a CMD_ST transmit or reset.
REQ-027 SEND SHALL last exactly one cycle with o_tx_start=1, then -> WAIT_DONE; the command-to-o_tx_start latency is 1 cycle.
REQ-028 o_tx_data SHALL be loaded on entry to SEND and held stable until the next SEND.
REQ-029 WAIT_DONE + i_tx_done -> IDLE; no timeout in WAIT_DONE.
REQ-030 i_rx_valid during SEND or WAIT_DONE SHALL be discarded and SHALL pulse o_drop in the same cycle.
REQ-031 i_rx_valid coincident with i_tx_done in WAIT_DONE SHALL be dropped; the FSM returns to IDLE.
REQ-032 i_tx_done outside WAIT_DONE SHALL be ignored.
REQ-033 A new write SHALL overwrite its register; flags are never cleared except by reset.

Reset
REQ-034 With rst high at a clock edge: state=IDLE; o_A, o_B, o_op, o_tx_data=0; o_tx_start, o_busy, o_drop=0; all flags and the timeout counter=0.
REQ-035 rst SHALL take priority over every event, including mid-transmit; no o_tx_start SHALL issue in the cycle after reset.

Verification
REQ-036 01,05 / 02,03 / 03,07, then 04 with i_result=8'h08 -> o_A=5, o_B=3, o_op=7; o_tx_start 1 cycle after 04 with o_tx_data=8'h08.
REQ-037 After reset, send 04 -> o_tx_data=8'hEE; then send 05 -> status=8'h00.
REQ-038 Send 09 -> ERR_CODE transmitted; then send 05 -> 8'h08; a second 05 -> 8'h00 (flag cleared).
REQ-039 Send 01, then no bytes for TIMEOUT cycles -> ERR_CODE transmitted; o_A unchanged; a following status byte has bit 4 set.
REQ-040 Send 04, then 3 bytes before i_tx_done -> 3 o_drop pulses, registers unchanged, o_busy high until i_tx_done.
REQ-041 Assert rst in WAIT_DONE -> all outputs 0, state IDLE; a later 01,AA sets o_A=8'hAA normally.
